// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and helpers for the arb_mux_n stream multiplexer
//               (arbitration mode enum, index-width helper).
// Revision    : 1.0  initial release
// ============================================================================
package mux_pkg;

  // Arbitration policy selected at elaboration time
  typedef enum logic [1:0] {
    MUX_FIXED = 2'd0,
    MUX_RR    = 2'd1,
    MUX_EXT   = 2'd2
  } mux_mode_e;

  // Index width for n channels; never returns 0 so a 1-channel corner
  // still produces a legal vector width.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/arb_mux_n_if.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_n_if
// Description : Stream bundle for arb_mux_n: N producer channels in, one
//               registered consumer channel out, plus external select.
//               master = producer/consumer side, slave = multiplexer side.
// Revision    : 1.0  initial release
// ============================================================================
interface arb_mux_n_if
  import mux_pkg::*;
#(
  parameter int DW = 32,
  parameter int N  = 4
);

  localparam int SW = idx_width(N);

  // producer side
  logic [N-1:0]         in_valid;
  logic [N-1:0][DW-1:0] in_data;
  logic [N-1:0]         in_ready;
  logic [SW-1:0]        ext_sel;

  // consumer side
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [SW-1:0]        out_sel;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, ext_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, ext_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface : arb_mux_n_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority arbiter. The search begins at
//               ptr (or at 0 when fixed=1) and walks upward modulo N; the
//               first asserted request wins. Works for non-power-of-two N.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          fixed,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          grant_vld
);

  // One extra bit so start+offset never overflows before the modulo fold
  localparam logic [SW:0] c_n = (SW + 1)'(N);

  logic [SW:0]   start_w;
  logic [SW:0]   cand_w;
  logic [SW-1:0] cand_idx;
  logic          found;

  // Walk offsets 0..N-1 from the start point, folding back below N
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand_w    = '0;
    cand_idx  = '0;
    start_w   = fixed ? '0 : {1'b0, ptr};
    for (int k = 0; k < N; k++) begin
      cand_w = start_w + (SW + 1)'(k);
      if (cand_w >= c_n) begin
        cand_w = cand_w - c_n;
      end
      cand_idx = cand_w[SW-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
    grant_vld = found;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_n
// Description : N-input valid/ready stream multiplexer with selectable
//               arbitration (fixed priority, round-robin, external select)
//               and a registered output stage. One beat per cycle with no
//               bubble on simultaneous drain and refill.
// Revision    : 1.0  initial release
// ============================================================================
module arb_mux_n
  import mux_pkg::*;
#(
  parameter int        DW   = 32,
  parameter int        N    = 4,
  parameter mux_mode_e MODE = MUX_RR
) (
  input  logic       clk,
  input  logic       rst_n,
  arb_mux_n_if.slave bus
);

  localparam int            SW     = idx_width(N);
  localparam logic [SW-1:0] c_last = SW'(N - 1);
  localparam logic          c_fixd = (MODE == MUX_FIXED);
  localparam logic          c_ext  = (MODE == MUX_EXT);
  localparam logic          c_rr   = (MODE == MUX_RR);

  // registered state
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  // arbitration results
  logic [N-1:0]  arb_grant;
  logic [SW-1:0] arb_idx;
  logic          arb_vld;
  logic [N-1:0]  ext_grant;
  logic          ext_vld;
  logic [N-1:0]  grant;
  logic [SW-1:0] g_idx;
  logic          g_vld;
  logic          load;

  // Output register may accept a new beat when empty or being drained
  assign load = !out_valid_q || bus.out_ready;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .fixed     (c_fixd),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // External steering: grant only a valid channel whose index matches;
  // an out-of-range ext_sel matches no channel and so grants nothing.
  always_comb begin
    ext_grant = '0;
    for (int i = 0; i < N; i++) begin
      ext_grant[i] = (bus.ext_sel == SW'(i)) && bus.in_valid[i];
    end
    ext_vld = |ext_grant;
  end

  // Pick the grant source for the configured mode
  always_comb begin
    if (c_ext) begin
      grant = ext_grant;
      g_idx = bus.ext_sel;
      g_vld = ext_vld;
    end else begin
      grant = arb_grant;
      g_idx = arb_idx;
      g_vld = arb_vld;
    end
  end

  // Accept only when the output stage can take the beat
  assign bus.in_ready = load ? grant : '0;

  // Next-state for output stage and rotation pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = g_vld;
      if (g_vld) begin
        out_data_d = bus.in_data[g_idx];
        out_sel_d  = g_idx;
        if (c_rr) begin
          ptr_d = (g_idx == c_last) ? '0 : g_idx + 1'b1;
        end
      end
    end
  end

  // State registers, cleared asynchronously so an in-flight beat is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule : arb_mux_n
`default_nettype wire

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-input, valid/ready stream multiplexer with a built-in arbiter and a registered output stage. It is the successor to the fixed 4:1 combinational select mux: it generalises width and channel count, and adds selectable arbitration (fixed-priority, round-robin, or externally steered). It also adds per-channel backpressure. It sits wherever several producers share one consumer, e.g. writeback-source selection, or merging memory requests from fetch and load/store.

## Interface
- `DW`, default 32: data width per channel.
- `N`, default 4: number of input channels (N ≥ 2).
- `MODE`, default `MUX_RR`: arbitration mode. One of `MUX_FIXED`, `MUX_RR`, `MUX_EXT`.
- `SW`, derived as `$clog2(N)`: select/index width. Not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  N  per-channel request.
- `in_data`  in  N×DW  per-channel payload, packed array `[N-1:0][DW-1:0]`.
- `in_ready`  out  N  per-channel accept; combinational, at most one bit high.
- `ext_sel`  in  SW  channel select, used only when `MODE == MUX_EXT`.
- `out_valid`  out  1  registered output valid.
- `out_data`  out  DW  registered payload.
- `out_sel`  out  SW  index of the channel that produced `out_data`.
- `out_ready`  in  1  consumer accept.

## Operation
- **Load condition:** `load = !out_valid || out_ready`. No grant is issued when `load` is 0.
- **`MUX_FIXED`:** the lowest-index asserted `in_valid` wins.
- **`MUX_RR`:** the search starts at pointer `ptr` and proceeds upward modulo N; the first asserted `in_valid` wins.
- **`MUX_EXT`:** the grant goes to `ext_sel` only if `in_valid[ext_sel]` is 1. If `ext_sel ≥ N`, nothing is granted.
- **Handshake output:** `in_ready[i] = load && grant[i]`. A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- **On transfer:**
  - `out_data` ← `in_data[g]`
  - `out_sel` ← g
  - `out_valid` ← 1
  - In `MUX_RR` only: `ptr` ← (g+1) mod N, wrapping from N-1 to 0.
- **Drain without refill:** if `load` is 1 and there is no grant, `out_valid` ← 0. `out_data` and `out_sel` hold their last values.
- **Stall:** when `out_valid && !out_ready`, `out_data`, `out_sel` and `ptr` hold, and all `in_ready` bits are 0.
- **Pointer stability:** `ptr` is unchanged in cycles with no transfer, and is never advanced by a request that was not accepted.
- **Index width:** N need not be a power of two. `ptr` and all index arithmetic use SW bits with explicit modulo-N wrap.

## Timing
- **Reset values** (asynchronous, while `rst_n` = 0): `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0. `in_ready` is therefore all-zero-gated only by grant; `load` = 1.
- **Latency:** 1 cycle from input transfer to `out_valid`.
- **Throughput:** 1 transfer per cycle while `out_ready` is held high.
- **Simultaneous drain and refill:** in the same cycle the old beat leaves and the new beat loads. There is no bubble.
- **Reset mid-transfer:** the in-flight beat is discarded, and `ptr` returns to 0 immediately (asynchronously).
- **Combinational paths:** `in_ready` depends combinationally on `in_valid`, `ext_sel`, `out_valid`, `out_ready` and `ptr`. There is no path from any input to `out_valid`, `out_data` or `out_sel`.
- **Producer rule:** producers must not make `in_valid` depend on `in_ready`.

## Structure
- **Package `mux_pkg`:**
  - `typedef enum logic [1:0] {MUX_FIXED, MUX_RR, MUX_EXT} mux_mode_e;`
  - a `clog2`-safe index-width helper function.
- **Sub-module `rr_arbiter #(N)`:**
  - Inputs: `req[N]`, `ptr`, `fixed`.
  - Output: one-hot `grant[N]` plus the binary index of the grant.
  - Purely combinational. `fixed` = 1 forces the search to start at 0.
- **Top level:** instantiates `rr_arbiter`, the `MUX_EXT` override, the output register and the `ptr` register.

## Test plan
1. **Round-robin rotation.** Setup: `MODE=MUX_RR`, N=4, all `in_valid` = 1, `out_ready` = 1, `in_data[i] = 32'hA0+i`. Expect: `out_sel` sequence 0,1,2,3,0 starting the cycle after reset release, one beat per cycle.
2. **Fixed priority.** Setup: `MODE=MUX_FIXED`, `in_valid` = 4'b1010. Expect: only channel 1 is accepted, every cycle. Channel 3 is never granted until `in_valid[1]` drops; then `out_sel` = 3.
3. **Backpressure.** Setup: `MUX_RR`, beat from ch2 (`in_data[2] = 32'hDEAD_BEEF`) loaded, then `out_ready` held 0 for 3 cycles. Expect: `out_data` = `32'hDEAD_BEEF` and `out_sel` = 2 stable throughout, `in_ready` = 0, `ptr` = 3 unchanged. When `out_ready` rises, the next beat loads in the same cycle.
4. **External select.** Setup: `MODE=MUX_EXT`, `ext_sel` = 2, `in_valid` = 4'b0011. Expect: no grant, and `out_valid` falls after the drain. Then set `in_valid[2]` = 1. Expect: `in_ready` = 4'b0100 and `out_sel` = 2 on the next cycle.
5. **Non-power-of-two wrap.** Setup: N=3, `MUX_RR`, all valid. Expect: `out_sel` 0,1,2,0,1; `ptr` never takes the value 3.
6. **Reset mid-stream.** Stimulus: assert `rst_n` = 0 asynchronously while `out_valid` = 1. Expect: outputs go to 0 immediately, before the next edge. After release, the first grant starts at ch0.
